ccu_send_arbiter: RTL

- Shares the single SPI TX AXI4-Stream between two packet sources: src0 (ADC data return, type 8'h12) and src1 (CCU responses/acks).
- For each granted request it emits the 5-byte packet header (id, type, length), then forwards exactly `length` payload bytes from the granted source.
- Asserts tlast on the final byte of each packet.
- Sits between the CCU/ADC sources and the SPI slave TX interface; it is the only driver of spi_send_axis_*.

---
 rtl/ccu_pkg.sv | 44 ++++
 rtl/ccu_rr_arbiter2.sv | 45 ++++
 rtl/ccu_send_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ccu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ccu_pkg
//  Purpose  : Shared CCU definitions: packet type codes, header size, send
//             FSM state encoding and the header byte selector.
//  Revision : 1.0 - initial release
// ============================================================================
package ccu_pkg;

  // Packet type codes carried in header byte 2
  localparam logic [7:0] PACKAGE_TYPE_H00      = 8'h00;
  localparam logic [7:0] PACKAGE_TYPE_H11      = 8'h11;
  localparam logic [7:0] PACKAGE_TYPE_ADC_DATA = 8'h12;
  localparam logic [7:0] PACKAGE_TYPE_H21      = 8'h21;
  localparam logic [7:0] PACKAGE_TYPE_H22      = 8'h22;

  // Header is id[15:8], id[7:0], type, length[15:8], length[7:0]
  localparam int HDR_BYTES = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } send_state_e;

  // Returns header byte number idx of a packet
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] id,
                                          input logic [7:0]  typ,
                                          input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      3'd0:    b = id[15:8];
      3'd1:    b = id[7:0];
      3'd2:    b = typ;
      3'd3:    b = len[15:8];
      default: b = len[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccu_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : ccu_rr_arbiter2
//  Purpose  : Two-way round-robin arbiter. A lone requester wins outright;
//             on contention the source not granted last wins. The history
//             register only moves when update_en is pulsed.
//  Revision : 1.0 - initial release
// ============================================================================
module ccu_rr_arbiter2 #(
  parameter bit SRC0_PRIORITY_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  input  logic       update_sel,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  // last_grant = 1 means src1 was served last, so src0 wins the next tie
  logic last_grant;

  // Combinational grant decision
  always_comb begin
    gnt_valid = |req;
    gnt_sel   = 1'b0;
    case (req)
      2'b10:   gnt_sel = 1'b1;
      2'b11:   gnt_sel = ~last_grant;
      default: gnt_sel = 1'b0;
    endcase
  end

  // Arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC0_PRIORITY_FIRST;
    end else if (update_en) begin
      last_grant <= update_sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccu_send_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ccu_send_arbiter
//  Purpose  : Shares the SPI TX byte stream between two packet sources.
//             Each granted request produces a 5-byte header followed by
//             exactly `length` payload bytes from the granted source, with
//             tlast on the final byte of the packet.
//  Revision : 1.0 - initial release
// ============================================================================
module ccu_send_arbiter
  import ccu_pkg::*;
#(
  parameter logic [15:0] ID_INIT             = 16'h0000,
  parameter bit          SRC0_PRIORITY_FIRST = 1'b1
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  // source 0
  input  logic        src0_req_valid,
  output logic        src0_req_ready,
  input  logic [7:0]  src0_req_type,
  input  logic [15:0] src0_req_length,
  input  logic [7:0]  src0_axis_tdata,
  input  logic        src0_axis_tvalid,
  output logic        src0_axis_tready,
  input  logic        src0_axis_tlast,
  // source 1
  input  logic        src1_req_valid,
  output logic        src1_req_ready,
  input  logic [7:0]  src1_req_type,
  input  logic [15:0] src1_req_length,
  input  logic [7:0]  src1_axis_tdata,
  input  logic        src1_axis_tvalid,
  output logic        src1_axis_tready,
  input  logic        src1_axis_tlast,
  // SPI TX stream
  output logic [7:0]  spi_send_axis_tdata,
  output logic        spi_send_axis_tvalid,
  input  logic        spi_send_axis_tready,
  output logic        spi_send_axis_tlast,
  // status
  output logic        int_send_finish,
  output logic        int_len_err,
  output logic        busy
);

  send_state_e state;
  logic [15:0] pack_id;
  logic [15:0] req_len;
  logic [7:0]  req_type;
  logic [15:0] pay_cnt;
  logic [2:0]  hdr_cnt;
  logic        gnt_src;
  logic        len_err_flag;

  logic        arb_valid;
  logic        arb_sel;
  logic        accept;
  logic        load_ok;
  logic        sel_tvalid;
  logic [7:0]  sel_tdata;
  logic        sel_tlast;
  logic        src_hs;
  logic        pay_last;
  logic        done_hs;

  // The output register can take a new byte when empty or draining this cycle
  assign load_ok = !spi_send_axis_tvalid || spi_send_axis_tready;

  assign accept         = (state == ST_IDLE) && arb_valid;
  assign src0_req_ready = accept && !arb_sel;
  assign src1_req_ready = accept &&  arb_sel;

  assign src0_axis_tready = (state == ST_PAYLOAD) && !gnt_src && load_ok;
  assign src1_axis_tready = (state == ST_PAYLOAD) &&  gnt_src && load_ok;

  assign sel_tvalid = gnt_src ? src1_axis_tvalid : src0_axis_tvalid;
  assign sel_tdata  = gnt_src ? src1_axis_tdata  : src0_axis_tdata;
  assign sel_tlast  = gnt_src ? src1_axis_tlast  : src0_axis_tlast;

  assign src_hs   = (state == ST_PAYLOAD) && sel_tvalid && load_ok;
  // Only evaluated in PAYLOAD, where req_len is known to be non-zero
  assign pay_last = (pay_cnt == (req_len - 16'd1));
  assign done_hs  = (state == ST_DONE) && spi_send_axis_tvalid && spi_send_axis_tready;

  // History advances when a packet completes, not when it is granted
  ccu_rr_arbiter2 #(
    .SRC0_PRIORITY_FIRST (SRC0_PRIORITY_FIRST)
  ) u_arb (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .req        ({src1_req_valid, src0_req_valid}),
    .update_en  (done_hs),
    .update_sel (gnt_src),
    .gnt_valid  (arb_valid),
    .gnt_sel    (arb_sel)
  );

  // Send FSM together with the single-entry output register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state                <= ST_IDLE;
      pack_id              <= ID_INIT;
      req_len              <= 16'd0;
      req_type             <= 8'd0;
      pay_cnt              <= 16'd0;
      hdr_cnt              <= 3'd0;
      gnt_src              <= 1'b0;
      len_err_flag         <= 1'b0;
      spi_send_axis_tdata  <= 8'd0;
      spi_send_axis_tvalid <= 1'b0;
      spi_send_axis_tlast  <= 1'b0;
      int_send_finish      <= 1'b0;
      int_len_err          <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      int_send_finish <= 1'b0;
      int_len_err     <= 1'b0;
      // A consumed byte empties the register unless a new one is loaded below
      if (spi_send_axis_tvalid && spi_send_axis_tready) begin
        spi_send_axis_tvalid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            gnt_src  <= arb_sel;
            req_type <= arb_sel ? src1_req_type   : src0_req_type;
            req_len  <= arb_sel ? src1_req_length : src0_req_length;
            hdr_cnt  <= 3'd0;
            busy     <= 1'b1;
            state    <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (load_ok) begin
            spi_send_axis_tdata  <= hdr_byte(hdr_cnt, pack_id, req_type, req_len);
            spi_send_axis_tvalid <= 1'b1;
            spi_send_axis_tlast  <= (hdr_cnt == 3'(HDR_BYTES - 1)) && (req_len == 16'd0);
            hdr_cnt              <= hdr_cnt + 3'd1;
            if (hdr_cnt == 3'(HDR_BYTES - 1)) begin
              pay_cnt <= 16'd0;
              state   <= (req_len == 16'd0) ? ST_DONE : ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (src_hs) begin
            spi_send_axis_tdata  <= sel_tdata;
            spi_send_axis_tvalid <= 1'b1;
            spi_send_axis_tlast  <= pay_last;
            // Length counter rules; the source tlast is only cross-checked
            if (sel_tlast != pay_last) begin
              len_err_flag <= 1'b1;
            end
            pay_cnt <= pay_cnt + 16'd1;
            if (pay_last) begin
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (done_hs) begin
            int_send_finish <= 1'b1;
            int_len_err     <= len_err_flag;
            len_err_flag    <= 1'b0;
            pack_id         <= pack_id + 16'd1;
            busy            <= 1'b0;
            state           <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
